// File: rtl/result_to_ascii.sv
// Converts a signed 32-bit evaluator result into a serial ASCII decimal string.
// A double-dabble BCD conversion runs first, then characters stream out with valid/ready.
module result_to_ascii #(
  parameter bit EMIT_NEWLINE = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_value,
  input  logic        in_overflow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last
);

  typedef enum logic [1:0] {StIdle, StConvert, StEmit, StEmitNl} state_e;

  state_e      state_q, state_d;
  logic [39:0] bcd_q, bcd_d;
  logic [31:0] mag_q, mag_d;
  logic        sign_q, sign_d;
  logic        ovf_q, ovf_d;
  logic [4:0]  step_q, step_d;
  logic [3:0]  rem_q, rem_d;

  logic [39:0] bcd_adj;
  logic [39:0] bcd_step;
  logic [3:0]  ndig;
  logic [5:0]  shamt;
  logic        last_char;
  logic        unused_bcd_top;

  // One double-dabble step, plus the digit count of its result for zero suppression.
  always_comb begin
    for (int i = 0; i < 10; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                   : bcd_q[4*i +: 4];
    end
    bcd_step = {bcd_adj[38:0], mag_q[31]};
    ndig = 4'd1;
    for (int i = 0; i < 10; i++) begin
      if (bcd_step[4*i +: 4] != 4'd0) ndig = 4'(i + 1);
    end
    shamt = 6'd40 - {ndig, 2'b00};
  end

  // The top digit never exceeds 4 for a 32-bit magnitude, so its carry-out is dead.
  assign unused_bcd_top = bcd_adj[39];

  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    mag_d     = mag_q;
    sign_d    = sign_q;
    ovf_d     = ovf_q;
    step_d    = step_q;
    rem_d     = rem_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_last  = 1'b0;
    last_char = (rem_q == 4'd1) && !sign_q;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          bcd_d  = '0;
          step_d = '0;
          if (in_overflow) begin
            ovf_d   = 1'b1;
            sign_d  = 1'b0;
            mag_d   = '0;
            rem_d   = 4'd3;
            state_d = StEmit;
          end else begin
            ovf_d   = 1'b0;
            sign_d  = in_value[31];
            mag_d   = in_value[31] ? (~in_value + 32'd1) : in_value;
            state_d = StConvert;
          end
        end
      end

      StConvert: begin
        bcd_d  = bcd_step;
        mag_d  = {mag_q[30:0], 1'b0};
        step_d = step_q + 5'd1;
        if (step_q == 5'd31) begin
          // Left-align the most significant nonzero digit so emission reads the top nibble.
          bcd_d   = bcd_step << shamt;
          rem_d   = ndig;
          state_d = StEmit;
        end
      end

      StEmit: begin
        out_valid = 1'b1;
        if (ovf_q) begin
          case (rem_q)
            4'd3:    out_data = 8'h4F;
            4'd2:    out_data = 8'h56;
            default: out_data = 8'h46;
          endcase
        end else if (sign_q) begin
          out_data = 8'h2D;
        end else begin
          out_data = {4'h3, bcd_q[39:36]};
        end
        out_last = last_char && !EMIT_NEWLINE;
        if (out_ready) begin
          if (last_char) begin
            state_d = EMIT_NEWLINE ? StEmitNl : StIdle;
          end else if (sign_q) begin
            sign_d = 1'b0;
          end else begin
            rem_d = rem_q - 4'd1;
            bcd_d = bcd_q << 4;
          end
        end
      end

      StEmitNl: begin
        out_valid = 1'b1;
        out_data  = 8'h0A;
        out_last  = 1'b1;
        if (out_ready) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      bcd_q   <= '0;
      mag_q   <= '0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
      step_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      mag_q   <= mag_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
      step_q  <= step_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_result_to_ascii.sv
// Directed bench for result_to_ascii: one instance without and one with the trailing newline.
module tb_result_to_ascii;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_value = '0;
  logic        in_overflow = 1'b0;
  logic        out_ready = 1'b1;
  logic        sel = 1'b0;

  logic       in_ready0, in_ready1, out_valid0, out_valid1, out_last0, out_last1;
  logic [7:0] out_data0, out_data1;
  logic       in_ready_m, out_valid_m, out_last_m;
  logic [7:0] out_data_m;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  result_to_ascii #(.EMIT_NEWLINE(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && !sel), .in_ready(in_ready0),
    .in_value(in_value), .in_overflow(in_overflow), .out_valid(out_valid0),
    .out_ready(out_ready), .out_data(out_data0), .out_last(out_last0)
  );

  result_to_ascii #(.EMIT_NEWLINE(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel), .in_ready(in_ready1),
    .in_value(in_value), .in_overflow(in_overflow), .out_valid(out_valid1),
    .out_ready(out_ready), .out_data(out_data1), .out_last(out_last1)
  );

  assign in_ready_m  = sel ? in_ready1  : in_ready0;
  assign out_valid_m = sel ? out_valid1 : out_valid0;
  assign out_last_m  = sel ? out_last1  : out_last0;
  assign out_data_m  = sel ? out_data1  : out_data0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic s, input logic [31:0] v, input logic ovf, output int acc);
    int guard = 0;
    sel = s;
    @(negedge clk);
    while (!in_ready_m && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_eq("send_ready", 96'(in_ready_m), 96'(1));
    in_valid    = 1'b1;
    in_value    = v;
    in_overflow = ovf;
    @(posedge clk);
    #1;
    acc      = cyc;
    in_valid = 1'b0;
  endtask

  task automatic receive(input bit toggle, output logic [95:0] str, output int nch,
                         output int first, output int stall_err, output int busy_err);
    bit         done = 1'b0;
    bit         rdy = 1'b1;
    bit         pv = 1'b0;
    bit         pr = 1'b1;
    logic [8:0] pd = '0;
    int         guard = 0;
    str = '0; nch = 0; first = -1; stall_err = 0; busy_err = 0;
    while (!done && guard < 300) begin
      @(negedge clk);
      guard++;
      out_ready = toggle ? rdy : 1'b1;
      rdy = !rdy;
      #1;
      if (in_ready_m) busy_err++;
      if (pv && !pr && (!out_valid_m || {out_last_m, out_data_m} != pd)) stall_err++;
      if (out_valid_m && first < 0) first = cyc;
      if (out_valid_m && out_ready) begin
        str = {str[87:0], out_data_m};
        nch++;
        done = out_last_m;
      end
      pv = out_valid_m;
      pr = out_ready;
      pd = {out_last_m, out_data_m};
    end
    check_eq("recv_last_seen", 96'(done), 96'(1));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
  endtask

  task automatic run(input string tag, input logic s, input logic [31:0] v, input logic ovf,
                     input bit toggle, input logic [95:0] exp, input int exp_len,
                     input int exp_lat);
    int          acc, nch, first, se, be;
    logic [95:0] str;
    send(s, v, ovf, acc);
    receive(toggle, str, nch, first, se, be);
    check_eq({tag, "_str"}, str, exp);
    check_eq({tag, "_len"}, 96'(nch), 96'(exp_len));
    check_eq({tag, "_lat"}, 96'(first - acc), 96'(exp_lat));
    check_eq({tag, "_stall"}, 96'(se), 96'(0));
    check_eq({tag, "_busy"}, 96'(be), 96'(0));
    check_eq({tag, "_ready_after"}, 96'(in_ready_m), 96'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"}, 96'(in_ready_m), 96'(1));
    check_eq({tag, "_out_valid"}, 96'(out_valid_m), 96'(0));
    check_eq({tag, "_out_data"}, 96'(out_data_m), 96'(0));
    check_eq({tag, "_out_last"}, 96'(out_last_m), 96'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    #12;
    sel = 1'b0; #1;
    check_reset_outputs("rst0");
    sel = 1'b1; #1;
    check_reset_outputs("rst1");
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    run("d521",  1'b0, 32'd521,        1'b0, 1'b0, 96'("521"),         3,  32);
    run("zero",  1'b0, 32'd0,          1'b0, 1'b0, 96'("0"),           1,  32);
    run("max",   1'b0, 32'h7FFF_FFFF,  1'b0, 1'b0, 96'("2147483647"),  10, 32);
    run("min",   1'b0, 32'h8000_0000,  1'b0, 1'b0, 96'("-2147483648"), 11, 32);
    run("ovf",   1'b0, 32'd123,        1'b1, 1'b0, 96'("OVF"),         3,  0);
    run("neg7",  1'b0, -32'sd7,        1'b0, 1'b1, 96'("-7"),          2,  32);
    run("billn", 1'b0, 32'd1000000000, 1'b0, 1'b1, 96'("1000000000"),  10, 32);
    run("nl42",  1'b1, 32'd42,         1'b0, 1'b0, {72'd0, "42", 8'h0A}, 3, 32);
    run("nlovf", 1'b1, 32'd5,          1'b1, 1'b0, {64'd0, "OVF", 8'h0A}, 4, 0);

    // Abort a conversion midway; only the next value's string may follow.
    send(1'b0, 32'd55, 1'b0, acc);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    run("post_rst", 1'b0, 32'd9, 1'b0, 1'b0, 96'("9"), 1, 32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
